coefficient_bank: RTL and testbench

- Multi-bank, double-buffered coefficient store for the spatial filter datapath.
- Coefficients stream in through a ready/valid handshake into a shadow shift register, then commit into one of NUM_BANKS active banks only on a frame boundary. Filter coefficients therefore never change mid-frame.
- The filter array reads the selected bank as one flat MASK_WIDTH×MASK_WIDTH word vector.

---
 rtl/coefficient_bank_if.sv | 11 +
 rtl/coefficient_bank.sv | 139 +++++++++++++
 tb/tb_coefficient_bank.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/coefficient_bank_if.sv
// Coefficient write stream: ready/valid handshake carrying one coefficient word per beat.
interface coefficient_bank_if #(
  parameter int COFCNT_BIT = 16
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [COFCNT_BIT-1:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/coefficient_bank.sv
// Double-buffered multi-bank coefficient store: shadow shift register loaded via handshake,
// committed into an active bank on frame_sync. Optional load checksum: COEF_CHECKSUM_EN.
module coefficient_bank #(
  parameter int COFCNT_BIT = 16,
  parameter int MASK_WIDTH = 7,
  parameter int BANK_BIT   = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       load_start,
  coefficient_bank_if.slave                          wr,
  input  logic [BANK_BIT-1:0]                        wr_bank,
  input  logic                                       commit,
  input  logic                                       frame_sync,
  input  logic [BANK_BIT-1:0]                        rd_bank,
  output logic [COFCNT_BIT*MASK_WIDTH*MASK_WIDTH-1:0] out_data,
  output logic                                       load_done,
  output logic                                       commit_done,
  output logic                                       overrun,
  output logic [COFCNT_BIT-1:0]                      chk_sum
);
  localparam int TAPS      = MASK_WIDTH * MASK_WIDTH;
  localparam int NUM_BANKS = 2 ** BANK_BIT;
  localparam int CNT_W     = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_PEND} state_t;
  typedef logic [TAPS-1:0][COFCNT_BIT-1:0] set_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  set_t                shadow_q, shadow_d;
  set_t                bank_q [NUM_BANKS];
  logic [BANK_BIT-1:0] pend_q, pend_d;
  logic [BANK_BIT-1:0] rd_bank_q;
  logic                commit_done_q, commit_done_d;
  logic                overrun_q;
  logic                acc;
  logic                bank_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // load_start outranks a same-cycle accept; that word is dropped.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    pend_d        = pend_q;
    commit_done_d = 1'b0;
    bank_we       = 1'b0;
    acc           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          cnt_d = '0;
        end else if (wr.wr_valid) begin
          acc      = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          shadow_d = {wr.wr_data, shadow_q[TAPS-1:1]};
          if (cnt_q == LAST) state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (commit) begin
          state_d = S_PEND;
          pend_d  = wr_bank;
        end
      end
      S_PEND: begin
        if (frame_sync) begin
          bank_we       = 1'b1;
          commit_done_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      shadow_q      <= '0;
      pend_q        <= '0;
      rd_bank_q     <= '0;
      commit_done_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
      commit_done_q <= commit_done_d;
      if (frame_sync) rd_bank_q <= rd_bank;
      if (wr.wr_valid && state_q != S_LOAD) overrun_q <= 1'b1;
    end
  end

  // Bank write and read-select update share the frame_sync edge, so the reader never sees a mix.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_q[b] <= '0;
    end else if (bank_we) begin
      bank_q[pend_q] <= shadow_q;
    end
  end

`ifdef COEF_CHECKSUM_EN
  logic [COFCNT_BIT-1:0] chk_q;
  logic                  chk_clr;
  assign chk_clr = load_start && (state_q != S_PEND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        chk_q <= '0;
    else if (chk_clr) chk_q <= '0;
    else if (acc)     chk_q <= chk_q + wr.wr_data;
  end
  assign chk_sum = chk_q;
`else
  assign chk_sum = '0;
`endif

  assign wr.wr_ready  = (state_q == S_LOAD);
  assign load_done    = (state_q == S_FULL);
  assign commit_done  = commit_done_q;
  assign overrun      = overrun_q;
  assign out_data     = bank_q[rd_bank_q];
endmodule

// File: tb/tb_coefficient_bank.sv
// Scoreboard bench for coefficient_bank: queue-based reference model, randomized stimulus.
`timescale 1ns/1ps
module tb_coefficient_bank;
  localparam int W    = 16;
  localparam int MW   = 7;
  localparam int TAPS = MW * MW;
  localparam int BB   = 1;
  localparam int NB   = 2 ** BB;

  typedef logic [W*TAPS-1:0] vec_t;
  typedef enum {M_IDLE, M_LOAD, M_FULL, M_PEND} mmode_t;

  logic          clk = 1'b0;
  logic          reset, load_start, commit, frame_sync;
  logic [BB-1:0] wr_bank, rd_bank;
  vec_t          out_data;
  logic          load_done, commit_done, overrun;
  logic [W-1:0]  chk_sum;

  coefficient_bank_if #(.COFCNT_BIT(W)) wr_if ();

  coefficient_bank #(.COFCNT_BIT(W), .MASK_WIDTH(MW), .BANK_BIT(BB)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .wr(wr_if),
    .wr_bank(wr_bank), .commit(commit), .frame_sync(frame_sync), .rd_bank(rd_bank),
    .out_data(out_data), .load_done(load_done), .commit_done(commit_done),
    .overrun(overrun), .chk_sum(chk_sum)
  );

  always #5 clk = ~clk;

  // reference model: shadow is a sliding window of the last TAPS accepted words
  mmode_t       m_mode;
  int           m_cnt, m_rd, m_pend;
  logic [W-1:0] m_sh[$];
  vec_t         m_bank[NB];
  bit           m_ovr, m_cd;
  logic [W-1:0] m_sum;
  vec_t         exp_q[$];
  int           n_cmp = 0, n_err = 0;

  task automatic cmp(string nm, vec_t act, vec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t pack_shadow();
    vec_t v;
    for (int i = 0; i < TAPS; i++) v[i*W +: W] = m_sh[i];
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_rd = 0; m_pend = 0;
    m_ovr = 0; m_cd = 0; m_sum = '0;
    m_sh.delete();
    for (int i = 0; i < TAPS; i++) m_sh.push_back('0);
    for (int b = 0; b < NB; b++) m_bank[b] = '0;
    exp_q.delete();
  endtask

  task automatic step();
    mmode_t nm; int nc, npend; bit acc, we, clr, nov, fs;
    logic [W-1:0] d; logic [BB-1:0] rb;
    nm = m_mode; nc = m_cnt; npend = m_pend; nov = m_ovr;
    acc = 0; we = 0; clr = 0;
    d = wr_if.wr_data; fs = frame_sync; rb = rd_bank;
    if (wr_if.wr_valid && m_mode != M_LOAD) nov = 1;
    case (m_mode)
      M_IDLE: if (load_start) begin nm = M_LOAD; nc = 0; clr = 1; end
      M_LOAD: if (load_start) begin nc = 0; clr = 1; end
              else if (wr_if.wr_valid) begin
                acc = 1; nc = m_cnt + 1;
                if (nc == TAPS) nm = M_FULL;
              end
      M_FULL: if (load_start) begin nm = M_LOAD; nc = 0; clr = 1; end
              else if (commit) begin nm = M_PEND; npend = int'(wr_bank); end
      M_PEND: if (fs) begin we = 1; nm = M_IDLE; end
    endcase
    @(posedge clk);
    if (we) m_bank[m_pend] = pack_shadow();
    if (acc) begin m_sh.push_back(d); void'(m_sh.pop_front()); m_sum = m_sum + d; end
    if (clr) m_sum = '0;
    if (fs) m_rd = int'(rb);
    m_mode = nm; m_cnt = nc; m_pend = npend; m_ovr = nov; m_cd = we;
    if (we) exp_q.push_back(m_bank[m_rd]);
    #1;
  endtask

  task automatic drive(bit ls, bit v, logic [W-1:0] d, bit cm, logic [BB-1:0] wb,
                       bit fs, logic [BB-1:0] rb);
    load_start = ls; wr_if.wr_valid = v; wr_if.wr_data = d; commit = cm;
    wr_bank = wb; frame_sync = fs; rd_bank = rb;
    step();
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic load_seq(int base, bit rnd);
    drive(1, 0, '0, 0, '0, 0, '0);
    for (int i = 0; i < TAPS; i++)
      drive(0, 1, rnd ? W'($urandom) : W'(base + i), 0, '0, 0, '0);
  endtask

  task automatic check_zero(string tag);
    cmp({tag, "_out_data"}, out_data, '0);
    cmp({tag, "_load_done"}, vec_t'(load_done), '0);
    cmp({tag, "_wr_ready"}, vec_t'(wr_if.wr_ready), '0);
    cmp({tag, "_commit_done"}, vec_t'(commit_done), '0);
    cmp({tag, "_overrun"}, vec_t'(overrun), '0);
    cmp({tag, "_chk_sum"}, vec_t'(chk_sum), '0);
  endtask

  // monitor: per-cycle flag/data checks plus scoreboard pop on each commit_done
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cmp("wr_ready", vec_t'(wr_if.wr_ready), vec_t'(m_mode == M_LOAD));
        cmp("load_done", vec_t'(load_done), vec_t'(m_mode == M_FULL));
        cmp("overrun", vec_t'(overrun), vec_t'(m_ovr));
        cmp("commit_done", vec_t'(commit_done), vec_t'(m_cd));
`ifdef COEF_CHECKSUM_EN
        cmp("chk_sum", vec_t'(chk_sum), vec_t'(m_sum));
`else
        cmp("chk_sum", vec_t'(chk_sum), '0);
`endif
        cmp("out_data", out_data, m_bank[m_rd]);
        if (commit_done) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL commit_unexpected: got commit_done=1 expected no pending commit");
          end else begin
            e = exp_q.pop_front();
            cmp("commit_data", out_data, e);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; load_start = 0; commit = 0; frame_sync = 0;
    wr_bank = '0; rd_bank = '0; wr_if.wr_valid = 0; wr_if.wr_data = '0;
    model_reset();
    #12;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // basic load 1..49, backpressured 50th word, commit to bank 1 held 10 cycles
    load_seq(1, 0);
    drive(0, 1, W'(50), 0, '0, 0, '0);
    drive(0, 0, '0, 1, 1'b1, 0, '0);
    idle(10);
    drive(0, 0, '0, 0, '0, 1, 1'b1);
    idle(2);
    cmp("basic_word0", vec_t'(out_data[0 +: W]), vec_t'(1));
    cmp("basic_word48", vec_t'(out_data[48*W +: W]), vec_t'(49));
    drive(0, 0, '0, 0, '0, 1, 1'b0);
    idle(1);
    cmp("bank0_untouched", out_data, '0);

    // same-edge commit into the displayed bank: A then B into bank 0
    load_seq(0, 1);
    drive(0, 0, '0, 1, 1'b0, 0, '0);
    idle(3);
    drive(0, 0, '0, 0, '0, 1, 1'b0);
    load_seq(0, 1);
    drive(0, 0, '0, 1, 1'b0, 0, '0);
    idle(2);
    drive(0, 0, '0, 0, '0, 1, 1'b0);
    idle(2);

    // restart mid-load with a dropped simultaneous word
    drive(1, 0, '0, 0, '0, 0, '0);
    for (int i = 0; i < 20; i++) drive(0, 1, W'($urandom), 0, '0, 0, '0);
    drive(1, 1, W'(16'hDEAD), 0, '0, 0, '0);
    for (int i = 0; i < TAPS; i++) drive(0, 1, W'(100 + i), 0, '0, 0, '0);
    drive(0, 0, '0, 1, 1'b1, 0, '0);
    drive(0, 0, '0, 0, '0, 1, 1'b1);
    idle(1);
    cmp("restart_word0", vec_t'(out_data[0 +: W]), vec_t'(100));

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bit ls, cm;
      ls = ($urandom_range(0, 31) == 0);
      cm = !ls && ($urandom_range(0, 5) == 0);
      drive(ls, ($urandom_range(0, 3) != 0), W'($urandom), cm, BB'($urandom),
            ($urandom_range(0, 11) == 0), BB'($urandom));
    end
    idle(2);

    // async reset while pending
    drive(0, 0, '0, 0, '0, 1, 1'b1);
    load_seq(0, 1);
    drive(0, 0, '0, 1, 1'b1, 0, '0);
    idle(2);
    cmp("pend_reached", vec_t'(m_mode == M_PEND), vec_t'(1));
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    model_reset();
    @(posedge clk); #2 reset = 1'b0;
    drive(0, 0, '0, 0, '0, 1, 1'b1);
    idle(3);
    cmp("post_reset_bank1", out_data, '0);

    idle(2);
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL commit_missing: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
